sign_mag_pipe: RTL and testbench

//  Two-stage valid/ready pipeline: converts a two's-complement (or unsigned) operand

---
 rtl/lau_pkg.sv | 15 +
 rtl/NegC.sv | 28 ++
 rtl/sign_mag_pipe.sv | 112 +++++++++++
 tb/tb_sign_mag_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lau_pkg.sv
// Shared types for the LAU datapath blocks: speed selection and the
// sign/magnitude flag pair produced by sign_mag_pipe.
package lau_pkg;

    typedef enum logic [0:0] {
        FAST = 1'b0,
        SLOW = 1'b1
    } speed_e;

    typedef struct packed {
        logic sat;
        logic minneg;
    } sm_flags_t;

endpackage

// File: rtl/NegC.sv
// Conditional two's-complement negator: y = neg ? -a : a.
// FAST uses the vendor adder; SLOW builds an explicit ripple incrementer.
module NegC
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] a,
    input  logic             neg,
    output logic [width-1:0] y
);

    if (speed == FAST) begin : g_fast
        assign y = neg ? (~a + 1'b1) : a;
    end else begin : g_slow
        // invert-then-increment, with neg itself as the carry-in
        logic [width-1:0] carry;
        assign carry[0] = neg;
        for (genvar gi = 0; gi < width; gi++) begin : g_bit
            assign y[gi] = a[gi] ^ neg ^ carry[gi];
            if (gi < width - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] ^ neg) & carry[gi];
            end
        end
    end

endmodule

// File: rtl/sign_mag_pipe.sv
// Two-stage valid/ready pipeline converting an operand to sign + magnitude.
// Define LAU_SM_SAT_EN to clamp the most-negative signed input to 2^(width-1)-1.
module sign_mag_pipe
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter int     TagW  = 4,
    parameter speed_e speed = FAST
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [width-1:0] in_a_i,
    input  logic            in_signed_i,
    input  logic [TagW-1:0] in_tag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [width-1:0] out_mag_o,
    output logic            out_sign_o,
    output logic [1:0]      out_flags_o,
    output logic [TagW-1:0] out_tag_o
);

    logic             s0_valid_reg;
    logic [width-1:0] s0_a_reg;
    logic             s0_signed_reg;
    logic [TagW-1:0]  s0_tag_reg;

    logic             s1_valid_reg;
    logic [width-1:0] s1_mag_reg;
    logic             s1_sign_reg;
    sm_flags_t        s1_flags_reg;
    logic [TagW-1:0]  s1_tag_reg;

    logic             s1_adv;
    logic             in_hs;
    logic             neg_next;
    logic             minneg_next;
    logic [width-1:0] neg_mag;
    logic [width-1:0] mag_next;
    sm_flags_t        flags_next;

    assign s1_adv     = s0_valid_reg & (~s1_valid_reg | out_ready_i);
    assign in_ready_o = ~s0_valid_reg | s1_adv;
    assign in_hs      = in_valid_i & in_ready_o;

    assign neg_next    = s0_signed_reg & s0_a_reg[width-1];
    assign minneg_next = neg_next & (s0_a_reg[width-2:0] == '0);

    NegC #(
        .width (width),
        .speed (speed)
    ) u_negc (
        .a   (s0_a_reg),
        .neg (neg_next),
        .y   (neg_mag)
    );

`ifdef LAU_SM_SAT_EN
    assign mag_next   = minneg_next ? {1'b0, {(width-1){1'b1}}} : neg_mag;
    assign flags_next = '{sat: minneg_next, minneg: minneg_next};
`else
    // -2^(width-1) negates to itself, which is the exact unsigned magnitude
    assign mag_next   = neg_mag;
    assign flags_next = '{sat: 1'b0, minneg: minneg_next};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid_reg  <= 1'b0;
            s0_a_reg      <= '0;
            s0_signed_reg <= 1'b0;
            s0_tag_reg    <= '0;
            s1_valid_reg  <= 1'b0;
            s1_mag_reg    <= '0;
            s1_sign_reg   <= 1'b0;
            s1_flags_reg  <= '0;
            s1_tag_reg    <= '0;
        end else if (flush_i) begin
            s0_valid_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            if (in_hs) begin
                s0_valid_reg  <= 1'b1;
                s0_a_reg      <= in_a_i;
                s0_signed_reg <= in_signed_i;
                s0_tag_reg    <= in_tag_i;
            end else if (s1_adv) begin
                s0_valid_reg <= 1'b0;
            end

            if (s1_adv) begin
                s1_valid_reg <= 1'b1;
                s1_mag_reg   <= mag_next;
                s1_sign_reg  <= neg_next;
                s1_flags_reg <= flags_next;
                s1_tag_reg   <= s0_tag_reg;
            end else if (out_ready_i) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid_o = s1_valid_reg;
    assign out_mag_o   = s1_mag_reg;
    assign out_sign_o  = s1_sign_reg;
    assign out_flags_o = s1_flags_reg;
    assign out_tag_o   = s1_tag_reg;

endmodule

// File: tb/tb_sign_mag_pipe.sv
// Directed + scoreboard bench for sign_mag_pipe (width=8, TagW=4).
// Honours LAU_SM_SAT_EN for the most-negative-operand expectations.
module tb_sign_mag_pipe;

`ifdef LAU_SM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] mag;
        logic       sign;
        logic [1:0] flags;
        logic [3:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic       in_signed = 1'b0;
    logic [3:0] in_tag = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_mag;
    logic       out_sign;
    logic [1:0] out_flags;
    logic [3:0] out_tag;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t held;
    exp_t got;
    exp_t want;
    logic last_in_hs = 1'b0;
    logic hold_pending = 1'b0;

    sign_mag_pipe #(
        .width (8),
        .TagW  (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_signed_i (in_signed),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_mag_o   (out_mag),
        .out_sign_o  (out_sign),
        .out_flags_o (out_flags),
        .out_tag_o   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(logic [7:0] a, logic sgn, logic [3:0] tag);
        exp_t e;
        e.tag   = tag;
        e.sign  = 1'b0;
        e.flags = 2'b00;
        e.mag   = a;
        if (sgn && a[7]) begin
            e.sign = 1'b1;
            if (a == 8'h80) begin
                e.mag   = SAT_EN ? 8'h7F : 8'h80;
                e.flags = SAT_EN ? 2'b11 : 2'b01;
            end else begin
                e.mag = 8'h00 - a;
            end
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, update scoreboard, return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        last_in_hs = 1'b0;
        if (rst_n) begin
            got = {out_mag, out_sign, out_flags, out_tag};
            if (hold_pending) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(got), 32'(held));
            end
            if (out_valid && out_ready) begin
                n_checks++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL out_unexpected: observed tag %0h mag %0h expected no output", out_tag, out_mag);
                end
                if (sb.size() > 0) begin
                    want = sb.pop_front();
                    chk("sb_mag", 32'(got.mag), 32'(want.mag));
                    chk("sb_sign", 32'(got.sign), 32'(want.sign));
                    chk("sb_flags", 32'(got.flags), 32'(want.flags));
                    chk("sb_tag", 32'(got.tag), 32'(want.tag));
                end
            end
            hold_pending = out_valid && !out_ready && !flush;
            held = got;
            if (flush) sb.delete();
            last_in_hs = in_valid && in_ready && !flush;
            if (last_in_hs) sb.push_back(model(in_a, in_signed, in_tag));
        end else begin
            hold_pending = 1'b0;
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(logic [7:0] a, logic sgn, logic [3:0] tag,
                                  logic [7:0] emag, logic esign, logic [1:0] eflags);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_signed = sgn;
        in_tag    = tag;
        cycle();
        chk("dir_accept", 32'(last_in_hs), 32'd1);
        in_valid = 1'b0;
        cycle();
        chk("dir_valid", 32'(out_valid), 32'd1);
        chk("dir_mag", 32'(out_mag), 32'(emag));
        chk("dir_sign", 32'(out_sign), 32'(esign));
        chk("dir_flags", 32'(out_flags), 32'(eflags));
        chk("dir_tag", 32'(out_tag), 32'(tag));
        cycle();
    endtask

    initial begin
        int acc;
        int guard;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_mag", 32'(out_mag), 32'd0);
        chk("rst_sign", 32'(out_sign), 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            cycle();
            chk("idle_valid", 32'(out_valid), 32'd0);
        end

        send_and_check(8'hF6, 1'b1, 4'h3, 8'h0A, 1'b1, 2'b00);
        send_and_check(8'h0A, 1'b1, 4'h4, 8'h0A, 1'b0, 2'b00);
        send_and_check(8'hF6, 1'b0, 4'h5, 8'hF6, 1'b0, 2'b00);
        send_and_check(8'h80, 1'b1, 4'h6, SAT_EN ? 8'h7F : 8'h80, 1'b1, SAT_EN ? 2'b11 : 2'b01);
        send_and_check(8'h80, 1'b0, 4'h7, 8'h80, 1'b0, 2'b00);
        send_and_check(8'h00, 1'b1, 4'h8, 8'h00, 1'b0, 2'b00);
        send_and_check(8'h81, 1'b1, 4'h9, 8'h7F, 1'b1, 2'b00);

        // full throughput with downstream always ready
        acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_a      = 8'(i * 13);
            in_signed = 1'b1;
            in_tag    = 4'(i);
            cycle();
            if (last_in_hs) acc++;
        end
        chk("throughput", 32'(acc), 32'd20);
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("tp_drain", 32'(sb.size()), 32'd0);

        // stream 0..255 with random backpressure
        for (int i = 0; i < 256; i++) begin
            in_valid  = 1'b1;
            in_a      = 8'(i);
            in_signed = 1'($urandom_range(0, 1));
            in_tag    = 4'(i % 16);
            guard = 0;
            do begin
                out_ready = ($urandom_range(0, 3) != 0);
                cycle();
                guard++;
            end while (!last_in_hs && guard < 50);
            chk("stream_accept", 32'(last_in_hs), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("stream_drain", 32'(sb.size()), 32'd0);

        // stall: two accepted, third refused, then flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_signed = 1'b1;
        in_a = 8'h01; in_tag = 4'h1;
        cycle();
        chk("stall_acc1", 32'(last_in_hs), 32'd1);
        in_a = 8'h02; in_tag = 4'h2;
        cycle();
        chk("stall_acc2", 32'(last_in_hs), 32'd1);
        in_a = 8'h03; in_tag = 4'h3;
        chk("stall_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("stall_acc3", 32'(last_in_hs), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_head", 32'(out_tag), 32'd1);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_sb", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("flush_quiet", 32'(out_valid), 32'd0);

        // flush discards a handshake in the same cycle
        in_valid = 1'b1;
        in_a = 8'h05; in_tag = 4'h5;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("flush_drop", 32'(out_valid), 32'd0);

        // async reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(8'h40 + i);
            in_tag   = 4'(i);
            cycle();
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_mag", 32'(out_mag), 32'd0);
        hold_pending = 1'b0;
        sb.delete();
        in_valid = 1'b0;
        cycle();
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_rel_idle", 32'(out_valid), 32'd0);
        send_and_check(8'hF6, 1'b1, 4'hC, 8'h0A, 1'b1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
